// File: rtl/d_ff_mod_if.sv
// rtl/d_ff_mod_if.sv - data, reset-value and output bundle for the d_ff_mod flop
interface d_ff_mod_if #(
    parameter int WIDTH = 1
);
    logic [WIDTH-1:0] set;
    logic [WIDTH-1:0] d;
    logic [WIDTH-1:0] q;

    modport master (
        output set,
        output d,
        input  q
    );

    modport slave (
        input  set,
        input  d,
        output q
    );
endinterface

// File: rtl/d_ff_mod.sv
// rtl/d_ff_mod.sv - WIDTH independent D flops with async active-high reset to a per-bit value
module d_ff_mod #(
    parameter int WIDTH = 1
) (
    input  logic        clk,
    input  logic        rst,
    d_ff_mod_if.slave   bus
);

    logic [WIDTH-1:0] q_reg;

    // Capture d on each rising edge; reset loads the per-bit reset value without a clock
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_reg <= bus.set;
        end else begin
            q_reg <= bus.d;
        end
    end

    // While reset is held the output tracks set directly, so set changes during reset show at once
    always_comb begin
        bus.q = q_reg;
        if (rst) begin
            bus.q = bus.set;
        end
    end

endmodule

// File: tb/tb_d_ff_mod.sv
// tb/tb_d_ff_mod.sv - self-checking bench for d_ff_mod (1-bit and 4-bit instances)
module tb_d_ff_mod;

    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    // Reference: value the flop holds from its last update (edge capture or reset load)
    logic [3:0] m1;
    logic [3:0] m4;
    logic       g1;
    logic       g2;

    d_ff_mod_if #(.WIDTH(1)) bus1 ();
    d_ff_mod_if #(.WIDTH(4)) bus4 ();

    d_ff_mod #(.WIDTH(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
    d_ff_mod #(.WIDTH(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4));

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running expected finished");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b", tag, obs, exp);
        end
    endtask

    // Advance to the next rising edge, apply the flop rule to the model, return 2 units later
    task automatic tick();
        @(posedge clk);
        m1 = rst ? {3'b000, bus1.set} : {3'b000, bus1.d};
        m4 = rst ? bus4.set : bus4.d;
        #2;
    endtask

    // Compare both instances with the model: reset forces set, otherwise the stored value
    task automatic check_model(input string tag);
        check({tag, "_q1"}, {3'b000, bus1.q}, rst ? {3'b000, bus1.set} : m1);
        check({tag, "_q4"}, bus4.q, rst ? bus4.set : m4);
    endtask

    initial begin
        logic [4:0] seq;
        seq = 5'b01101;
        m1 = '0;
        m4 = '0;
        g1 = 1'b0;
        g2 = 1'b0;

        // Reset value 0 with d=1, reset asserted from time zero
        rst = 1'b1; bus1.set = 1'b0; bus1.d = 1'b1;
        bus4.set = 4'b1010; bus4.d = 4'b0101;
        #3;
        check("rst0_async", {3'b000, bus1.q}, 4'b0000);
        check("w4_rst_1010", bus4.q, 4'b1010);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rst0_hold", {3'b000, bus1.q}, 4'b0000);
            check("w4_rst_hold", bus4.q, 4'b1010);
        end

        // Reset value 1: set changes while reset held, output follows immediately
        bus1.set = 1'b1; bus1.d = 1'b0;
        #1;
        check("rst1_follow", {3'b000, bus1.q}, 4'b0001);
        tick();
        check("rst1_edge", {3'b000, bus1.q}, 4'b0001);
        rst = 1'b0;
        #1;
        check("rst1_released", {3'b000, bus1.q}, 4'b0001);
        tick();
        check("rst1_capture0", {3'b000, bus1.q}, 4'b0000);

        // Capture sequence 1,0,1,1,0: q lags d by one edge and holds between edges
        for (int i = 0; i < 5; i++) begin
            bus1.d = seq[i];
            tick();
            check("capture_edge", {3'b000, bus1.q}, {3'b000, seq[i]});
            bus1.d = ~seq[i];
            #4;
            check("capture_hold", {3'b000, bus1.q}, {3'b000, seq[i]});
        end

        // Async reset half a cycle after an edge with q=1
        bus1.d = 1'b1;
        tick();
        check("mid_q1", {3'b000, bus1.q}, 4'b0001);
        #3;
        bus1.set = 1'b0; rst = 1'b1;
        #1;
        check("mid_async0", {3'b000, bus1.q}, 4'b0000);
        #1;
        rst = 1'b0; bus1.d = 1'b1;
        #1;
        check("mid_released", {3'b000, bus1.q}, 4'b0000);
        tick();
        check("mid_recapture", {3'b000, bus1.q}, 4'b0001);

        // set ignored while running
        bus1.d = 1'b0;
        tick();
        for (int i = 0; i < 4; i++) begin
            bus1.set = i[0];
            tick();
            check("set_ignored", {3'b000, bus1.q}, 4'b0000);
        end
        bus1.set = 1'b1; rst = 1'b1;
        #1;
        check("set_rst1", {3'b000, bus1.q}, 4'b0001);

        // Arbiter cell loop: d = ~g2 & (g1 | q)
        bus1.set = 1'b0;
        tick();
        rst = 1'b0;
        #1;
        check("arb_start", {3'b000, bus1.q}, 4'b0000);
        g1 = 1'b1; g2 = 1'b0;
        bus1.d = ~g2 & (g1 | bus1.q);
        tick();
        check("arb_set", {3'b000, bus1.q}, 4'b0001);
        g1 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus1.d = ~g2 & (g1 | bus1.q);
            tick();
            check("arb_hold", {3'b000, bus1.q}, 4'b0001);
        end
        g2 = 1'b1;
        bus1.d = ~g2 & (g1 | bus1.q);
        tick();
        check("arb_clear", {3'b000, bus1.q}, 4'b0000);

        // Randomized run against the model, both instances sharing reset
        for (int i = 0; i < 300; i++) begin
            rst      = ($urandom_range(0, 7) == 0);
            bus1.set = 1'($urandom);
            bus1.d   = 1'($urandom);
            bus4.set = 4'($urandom);
            bus4.d   = 4'($urandom);
            #1;
            check_model("rand_mid");
            tick();
            check_model("rand_edge");
        end

        rst = 1'b1; bus4.set = 4'b1010;
        #1;
        check("w4_final_rst", bus4.q, 4'b1010);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
